// File: rtl/ppfifo_pkg.sv
// Shared definitions for the ping-pong FIFO pattern generator and data checker:
// checker FSM encoding, default widths and the incrementing test pattern.
package ppfifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_SIZE_WIDTH = 24;
   localparam int PATTERN_WIDTH      = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACTIVATE,
      ST_CHECK,
      ST_POP,
      ST_RELEASE
   } checker_state_t;

   // Word n of every buffer carries n; callers truncate or extend to their data width.
   function automatic logic [PATTERN_WIDTH-1:0] pattern_word(input logic [PATTERN_WIDTH-1:0] index);
      return index;
   endfunction

endpackage

// File: rtl/ppfifo_data_checker_if.sv
// Read side of a ping-pong FIFO: buffer claim/release handshake plus word pop.
interface ppfifo_data_checker_if #(
   parameter int DATA_WIDTH = 32,
   parameter int SIZE_WIDTH = 24
);
   logic                  rd_rdy;
   logic                  rd_act;
   logic [SIZE_WIDTH-1:0] rd_size;
   logic                  rd_stb;
   logic [DATA_WIDTH-1:0] rd_data;

   // The consumer (checker) is the master of the claim and pop strobes.
   modport master (
      input  rd_rdy, rd_size, rd_data,
      output rd_act, rd_stb
   );

   modport slave (
      output rd_rdy, rd_size, rd_data,
      input  rd_act, rd_stb
   );
endinterface

// File: rtl/ppfifo_data_checker.sv
// Claims filled read buffers, pops every word at one word per two cycles and
// checks it against the incrementing pattern, tracking throughput and errors.
module ppfifo_data_checker
   import ppfifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int SIZE_WIDTH = DEFAULT_SIZE_WIDTH,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_enable,
   input  logic                  i_clear,
   ppfifo_data_checker_if.master rd,
   output logic                  o_busy,
   output logic [CNT_WIDTH-1:0]  o_buffer_count,
   output logic [CNT_WIDTH-1:0]  o_word_count,
   output logic [CNT_WIDTH-1:0]  o_error_count,
   output logic                  o_error,
   output logic [SIZE_WIDTH-1:0] o_first_err_index,
   output logic [DATA_WIDTH-1:0] o_first_err_data
);

   checker_state_t        state, state_next;
   logic [SIZE_WIDTH-1:0] r_size;
   logic [SIZE_WIDTH-1:0] r_idx;
   logic [DATA_WIDTH-1:0] expected;
   logic                  in_range;
   logic                  mismatch;

   assign in_range = (r_idx < r_size);
   assign expected = DATA_WIDTH'(pattern_word(PATTERN_WIDTH'(r_idx)));
   assign mismatch = (state == ST_CHECK) && in_range && (rd.rd_data != expected);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // NOTE: state_next gets its default first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:     if (i_enable && rd.rd_rdy) state_next = ST_ACTIVATE;
         ST_ACTIVATE: state_next = ST_CHECK;
         ST_CHECK:    state_next = in_range ? ST_POP : ST_RELEASE;
         ST_POP:      state_next = ST_CHECK;
         ST_RELEASE:  state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd.rd_act         <= 1'b0;
         rd.rd_stb         <= 1'b0;
         r_size            <= '0;
         r_idx             <= '0;
         o_busy            <= 1'b0;
         o_buffer_count    <= '0;
         o_word_count      <= '0;
         o_error_count     <= '0;
         o_error           <= 1'b0;
         o_first_err_index <= '0;
         o_first_err_data  <= '0;
      end else begin
         o_busy <= (state_next != ST_IDLE);

         case (state)
            ST_ACTIVATE: begin
               rd.rd_act <= 1'b1;
               r_size    <= rd.rd_size;
               r_idx     <= '0;
            end
            ST_CHECK:   if (in_range) rd.rd_stb <= 1'b1;
            ST_POP: begin
               rd.rd_stb <= 1'b0;
               r_idx     <= r_idx + 1'b1;
            end
            ST_RELEASE: rd.rd_act <= 1'b0;
            default: ;
         endcase

         // Clear outranks any same-cycle increment or error capture.
         if (i_clear) begin
            o_buffer_count    <= '0;
            o_word_count      <= '0;
            o_error_count     <= '0;
            o_error           <= 1'b0;
            o_first_err_index <= '0;
            o_first_err_data  <= '0;
         end else begin
            if (state == ST_POP)     o_word_count   <= o_word_count + 1'b1;
            if (state == ST_RELEASE) o_buffer_count <= o_buffer_count + 1'b1;
            if (mismatch) begin
               if (o_error_count != '1) o_error_count <= o_error_count + 1'b1;
               if (!o_error) begin
                  o_error           <= 1'b1;
                  o_first_err_index <= r_idx;
                  o_first_err_data  <= rd.rd_data;
               end
            end
         end
      end
   end

endmodule

// File: doc/ppfifo_data_checker.md
Name: ppfifo_data_checker

Overview:
- Consumer-side counterpart to the ping-pong FIFO pattern generator: claims filled read buffers, pops every word, and checks each against the expected incrementing pattern (word n of a buffer == n, zero-extended).
- Reports buffer and word throughput, error count, and the first mismatch.
- Sits on the read side of a ping-pong FIFO in loopback and DMA bring-up benches.

Parameters:
- DATA_WIDTH, 32, read data width; expected pattern is the buffer-relative index, zero-extended or truncated to this width.
- SIZE_WIDTH, 24, width of buffer size and word index.
- CNT_WIDTH, 32, width of buffer, word and error counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- i_enable  input  1  allow claiming new buffers.
- i_clear  input  1  synchronous clear of counters and error capture.
- i_rd_rdy  input  1  a filled buffer is available.
- o_rd_act  output  1  buffer claimed; held until release.
- i_rd_size  input  SIZE_WIDTH  word count of the offered buffer.
- o_rd_stb  output  1  pop one word; FIFO advances at the end of a strobe cycle.
- i_rd_data  input  DATA_WIDTH  current head word; valid while o_rd_act is high.
- o_busy  output  1  state is not IDLE.
- o_buffer_count  output  CNT_WIDTH  buffers fully consumed and released.
- o_word_count  output  CNT_WIDTH  words popped.
- o_error_count  output  CNT_WIDTH  mismatching words; saturates at all-ones.
- o_error  output  1  sticky; set on the first mismatch.
- o_first_err_index  output  SIZE_WIDTH  buffer index of the first mismatch.
- o_first_err_data  output  DATA_WIDTH  data received at the first mismatch.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs and internal index/size registers 0. Reset mid-buffer drops o_rd_act and o_rd_stb immediately.
- All outputs are registered.
- FSM states: IDLE, ACTIVATE, CHECK, POP, RELEASE.
- IDLE
  - If i_enable && i_rd_rdy: go to ACTIVATE.
  - Otherwise stay.
- ACTIVATE
  - o_rd_act<=1; latch i_rd_size into r_size; r_idx<=0; go to CHECK.
- CHECK
  - If r_idx < r_size:
    - Compare i_rd_data against the expected index.
    - o_rd_stb<=1; go to POP.
    - On mismatch: increment error count (saturating). If o_error==0, also set o_error and capture r_idx and i_rd_data.
  - Else (r_idx == r_size): go to RELEASE.
- POP
  - o_rd_stb is high for exactly this cycle.
  - o_rd_stb<=0; r_idx<=r_idx+1; o_word_count++; go to CHECK.
  - Throughput is 1 word per 2 cycles. Data checked in CHECK is always settled post-pop data.
- RELEASE
  - o_rd_act<=0; o_buffer_count++; go to IDLE.
  - A new claim is possible no earlier than 1 cycle after act falls.
- Latency from i_rd_rdy sampled in IDLE:
  - o_rd_act rises after 2 edges.
  - First o_rd_stb rises after 3 edges.
- Size-0 buffer: ACTIVATE -> CHECK -> RELEASE. No strobes; buffer_count still increments.
- i_enable deasserted mid-buffer: the current buffer is completed and released; no new claim is made.
- i_rd_rdy is ignored outside IDLE.
- i_clear
  - Zeroes o_buffer_count, o_word_count, o_error_count, o_error, o_first_err_*.
  - Does not affect the FSM or the handshake.
  - If it coincides with a mismatch or an increment, clear wins and that event is dropped.
- Counters o_buffer_count and o_word_count wrap modulo 2^CNT_WIDTH. o_error_count saturates.
- Index compare: expected value = r_idx zero-extended, or truncated if SIZE_WIDTH > DATA_WIDTH.

Decomposition:
- Shared package ppfifo_pkg holds:
  - state encoding for the checker FSM;
  - default width constants DATA_WIDTH=32, SIZE_WIDTH=24;
  - a function returning the expected pattern word for an index.
- The generator reuses the same pattern function.
- No sub-module; single FSM with the counters inline.

Test Plan:
- Generator-to-FIFO-to-checker loopback, size 16, 4 buffers -> buffer_count=4, word_count=64, error_count=0, o_error=0.
- FIFO model returns word 5 = 0xDEADBEEF in a size-8 buffer -> error_count=1, o_error=1, first_err_index=5, first_err_data=0xDEADBEEF. A later mismatch at index 7 leaves the capture unchanged and makes error_count=2.
- i_rd_size=0 with i_rd_rdy pulsed -> o_rd_act high 2 cycles, no o_rd_stb, buffer_count=1.
- Single rdy in IDLE -> act rises 2 edges later, first stb 3 edges later; stb is never high on consecutive cycles (checker asserts).
- i_enable dropped after 3 of 10 words -> all 10 popped, act released, the next i_rd_rdy is not claimed.
- rst asserted mid-buffer (asynchronous, between edges) -> o_rd_act and o_rd_stb go 0 immediately; counters 0. i_clear pulsed on a mismatch cycle -> error_count=0, o_error=0.
